tug_of_war_core: RTL and testbench

Parametrised tug-of-war game engine: a single lit position on an N-light bar moves left or right in response to one-shot player presses. A round is won by pressing while the light sits on your own end. The block keeps per-side scores up to a configurable match target and can substitute an LFSR-driven computer opponent, with adjustable difficulty, for the left player. It sits between the debounced board inputs, a game-rate tick enable and the LED/seven-segment drivers, replacing the per-light FSM chain and the separate winner/counter logic.

---
 rtl/tug_of_war_core.sv | 213 +++++++++++++++++++++
 tb/tb_tug_of_war_core.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tug_of_war_core.sv
`default_nettype none
// ============================================================================
//  Module   : tug_of_war_core
//  Purpose  : Tug-of-war game engine. A single lit position on an N-light
//             bar moves left/right on one-shot player presses. A round is won
//             by pressing while the light sits on your own end. Per-side
//             scores count up to WIN_SCORE. An LFSR-driven computer opponent
//             can replace the left player.
//  Ports    : clk_i, rst_ni (async, active-low)
//             tick_i        game-rate enable; game state advances on it
//             press_l_i/r_i raw player button levels
//             cpu_en_i      computer drives the left player
//             difficulty_i  CPU press threshold (0 = never presses)
//             new_match_i   clears scores and restarts the match
//             lights_o      one-hot bar, MSB is leftmost
//             score_l_o/r_o round wins per side
//             round_win_l_o/r_o one-cycle round-win pulses
//             match_over_o, winner_o (1 = left)
//  Revision : 1.0  initial release
// ============================================================================
module tug_of_war_core #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3,
  parameter int WIN_SCORE  = 7,
  parameter int HOLD_TICKS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  tick_i,
  input  logic                  press_l_i,
  input  logic                  press_r_i,
  input  logic                  cpu_en_i,
  input  logic [9:0]            difficulty_i,
  input  logic                  new_match_i,
  output logic [NUM_LIGHTS-1:0] lights_o,
  output logic [SCORE_W-1:0]    score_l_o,
  output logic [SCORE_W-1:0]    score_r_o,
  output logic                  round_win_l_o,
  output logic                  round_win_r_o,
  output logic                  match_over_o,
  output logic                  winner_o
);

  localparam int PW = $clog2(NUM_LIGHTS);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [PW-1:0]      POS_C   = PW'((NUM_LIGHTS - 1) / 2);
  localparam logic [PW-1:0]      POS_MAX = PW'(NUM_LIGHTS - 1);
  localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);
  localparam logic [HW-1:0]      HOLD_LD = HW'(HOLD_TICKS);

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HOLD = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Input conditioning, edge detection and CPU opponent
  // --------------------------------------------------------------------------
  logic [1:0] sync_l_q, sync_r_q;
  logic       prev_l_q, prev_r_q;
  logic [9:0] lfsr_q;
  logic       cpu_level, level_l, level_r, pulse_l, pulse_r;

  // Carry-out of lfsr + difficulty is set exactly when difficulty > ~lfsr
  // (i.e. difficulty > 1023 - lfsr), so no adder is needed.
  assign cpu_level = (difficulty_i > ~lfsr_q);
  assign level_l   = cpu_en_i ? cpu_level : sync_l_q[1];
  assign level_r   = sync_r_q[1];
  assign pulse_l   = tick_i & level_l & ~prev_l_q;
  assign pulse_r   = tick_i & level_r & ~prev_r_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_l_q <= '0;
      sync_r_q <= '0;
      prev_l_q <= 1'b0;
      prev_r_q <= 1'b0;
      lfsr_q   <= '0;
    end else begin
      sync_l_q <= {sync_l_q[0], press_l_i};
      sync_r_q <= {sync_r_q[0], press_r_i};
      // Previous levels sample only on ticks so one press = one pulse at game rate.
      if (tick_i) begin
        prev_l_q <= level_l;
        prev_r_q <= level_r;
        lfsr_q   <= {lfsr_q[8:0], ~(lfsr_q[9] ^ lfsr_q[6])};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Game state machine
  // --------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [PW-1:0]           pos_q, pos_d;
  logic [HW-1:0]           hold_q, hold_d;
  logic [SCORE_W-1:0]      score_l_q, score_l_d, score_r_q, score_r_d;
  logic                    rwin_l_q, rwin_l_d, rwin_r_q, rwin_r_d;
  logic                    over_q, over_d, winner_q, winner_d;
  logic [NUM_LIGHTS-1:0]   lights_q, lights_d;

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    hold_d    = hold_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    rwin_l_d  = 1'b0;
    rwin_r_d  = 1'b0;
    over_d    = over_q;
    winner_d  = winner_q;

    if (new_match_i) begin
      state_d   = ST_PLAY;
      pos_d     = POS_C;
      hold_d    = '0;
      score_l_d = '0;
      score_r_d = '0;
      over_d    = 1'b0;
      winner_d  = 1'b0;
    end else if (tick_i) begin
      case (state_q)
        ST_PLAY: begin
          if (pulse_l && !pulse_r) begin
            if (pos_q == POS_MAX) begin
              score_l_d = score_l_q + SCORE_W'(1);
              rwin_l_d  = 1'b1;
              if (score_l_d == WIN) begin
                state_d  = ST_OVER;
                over_d   = 1'b1;
                winner_d = 1'b1;
              end else begin
                state_d = ST_HOLD;
                hold_d  = HOLD_LD;
              end
            end else begin
              pos_d = pos_q + PW'(1);
            end
          end else if (pulse_r && !pulse_l) begin
            if (pos_q == '0) begin
              score_r_d = score_r_q + SCORE_W'(1);
              rwin_r_d  = 1'b1;
              if (score_r_d == WIN) begin
                state_d  = ST_OVER;
                over_d   = 1'b1;
                winner_d = 1'b0;
              end else begin
                state_d = ST_HOLD;
                hold_d  = HOLD_LD;
              end
            end else begin
              pos_d = pos_q - PW'(1);
            end
          end
        end
        ST_HOLD: begin
          hold_d = hold_q - HW'(1);
          if (hold_q == HW'(1)) begin
            state_d = ST_PLAY;
            pos_d   = POS_C;
          end
        end
        default: ;  // ST_OVER: frozen until new match
      endcase
    end

    // Lights are derived from next state so they are registered with it.
    lights_d = '0;
    case (state_d)
      ST_PLAY: lights_d = NUM_LIGHTS'(1) << pos_d;
      ST_OVER: lights_d = winner_d ? {1'b1, {(NUM_LIGHTS-1){1'b0}}}
                                   : NUM_LIGHTS'(1);
      default: lights_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_PLAY;
      pos_q     <= POS_C;
      hold_q    <= '0;
      score_l_q <= '0;
      score_r_q <= '0;
      rwin_l_q  <= 1'b0;
      rwin_r_q  <= 1'b0;
      over_q    <= 1'b0;
      winner_q  <= 1'b0;
      lights_q  <= NUM_LIGHTS'(1) << POS_C;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      hold_q    <= hold_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      rwin_l_q  <= rwin_l_d;
      rwin_r_q  <= rwin_r_d;
      over_q    <= over_d;
      winner_q  <= winner_d;
      lights_q  <= lights_d;
    end
  end

  assign lights_o      = lights_q;
  assign score_l_o     = score_l_q;
  assign score_r_o     = score_r_q;
  assign round_win_l_o = rwin_l_q;
  assign round_win_r_o = rwin_r_q;
  assign match_over_o  = over_q;
  assign winner_o      = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_tug_of_war_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tug_of_war_core
//  Purpose  : Directed self-checking bench for tug_of_war_core.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tug_of_war_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       press_l = 1'b0;
  logic       press_r = 1'b0;
  logic       cpu_en = 1'b0;
  logic [9:0] difficulty = 10'd0;
  logic       new_match = 1'b0;
  logic [8:0] lights;
  logic [2:0] score_l, score_r;
  logic       rwin_l, rwin_r, match_over, winner;

  int n_checks = 0;
  int n_pass   = 0;

  tug_of_war_core #(
    .NUM_LIGHTS(9), .SCORE_W(3), .WIN_SCORE(7), .HOLD_TICKS(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick),
    .press_l_i(press_l), .press_r_i(press_r),
    .cpu_en_i(cpu_en), .difficulty_i(difficulty), .new_match_i(new_match),
    .lights_o(lights), .score_l_o(score_l), .score_r_o(score_r),
    .round_win_l_o(rwin_l), .round_win_r_o(rwin_r),
    .match_over_o(match_over), .winner_o(winner)
  );

  always #5 clk = ~clk;

  // Three idle clocks then one tick cycle; returns 1 time unit after the tick edge.
  task automatic tick_once;
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_new_match;
    @(negedge clk);
    new_match = 1'b1;
    @(posedge clk);
    #1;
    new_match = 1'b0;
  endtask

  task automatic press_r_once;
    press_r = 1'b1;
    tick_once();
    press_r = 1'b0;
    tick_once();
  endtask

  task automatic press_l_once;
    press_l = 1'b1;
    tick_once();
    press_l = 1'b0;
    tick_once();
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    n_checks++;
    if (lights !== 9'b000010000) $display("FAIL reset_lights got=%b exp=%b", lights, 9'b000010000);
    else n_pass++;
    n_checks++;
    if (score_l !== 3'd0 || score_r !== 3'd0) $display("FAIL reset_scores got=%0d/%0d exp=0/0", score_l, score_r);
    else n_pass++;
    n_checks++;
    if (match_over !== 1'b0 || rwin_l !== 1'b0 || rwin_r !== 1'b0)
      $display("FAIL reset_flags got mo=%b rl=%b rr=%b exp=0,0,0", match_over, rwin_l, rwin_r);
    else n_pass++;
  endtask

  task automatic test_held_press;
    press_r = 1'b1;
    repeat (10) tick_once();
    n_checks++;
    if (lights !== 9'b000001000) $display("FAIL held_press got=%b exp=%b", lights, 9'b000001000);
    else n_pass++;
    press_r = 1'b0;
    tick_once();
  endtask

  task automatic test_round_win;
    pulse_new_match();
    repeat (4) press_r_once();
    n_checks++;
    if (lights !== 9'b000000001) $display("FAIL walk_right got=%b exp=%b", lights, 9'b000000001);
    else n_pass++;
    press_r = 1'b1;
    tick_once();
    n_checks++;
    if (rwin_r !== 1'b1 || score_r !== 3'd1 || lights !== 9'd0)
      $display("FAIL round_win got rw=%b sr=%0d l=%b exp rw=1 sr=1 l=0", rwin_r, score_r, lights);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (rwin_r !== 1'b0) $display("FAIL round_win_pulse got=%b exp=0", rwin_r);
    else n_pass++;
    press_r = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick_once();
      n_checks++;
      if (lights !== 9'd0) $display("FAIL hold_dark tick%0d got=%b exp=0", i, lights);
      else n_pass++;
    end
    tick_once();
    n_checks++;
    if (lights !== 9'b000010000) $display("FAIL hold_end got=%b exp=%b", lights, 9'b000010000);
    else n_pass++;
  endtask

  task automatic test_simultaneous;
    press_l = 1'b1;
    press_r = 1'b1;
    tick_once();
    n_checks++;
    if (lights !== 9'b000010000) $display("FAIL simultaneous got=%b exp=%b", lights, 9'b000010000);
    else n_pass++;
    press_l = 1'b0;
    press_r = 1'b0;
    tick_once();
    press_l = 1'b1;
    tick_once();
    n_checks++;
    if (lights !== 9'b000100000) $display("FAIL left_move got=%b exp=%b", lights, 9'b000100000);
    else n_pass++;
    press_l = 1'b0;
    tick_once();
  endtask

  task automatic test_match;
    pulse_new_match();
    for (int r = 0; r < 7; r++) begin
      repeat (5) press_r_once();
      repeat (3) tick_once();
    end
    n_checks++;
    if (match_over !== 1'b1 || winner !== 1'b0 || score_r !== 3'd7)
      $display("FAIL match_over got mo=%b w=%b sr=%0d exp mo=1 w=0 sr=7", match_over, winner, score_r);
    else n_pass++;
    n_checks++;
    if (lights !== 9'b000000001) $display("FAIL over_lights got=%b exp=%b", lights, 9'b000000001);
    else n_pass++;
    repeat (2) press_l_once();
    press_r_once();
    n_checks++;
    if (lights !== 9'b000000001 || score_l !== 3'd0 || score_r !== 3'd7)
      $display("FAIL over_frozen got l=%b sl=%0d sr=%0d exp l=000000001 sl=0 sr=7", lights, score_l, score_r);
    else n_pass++;
    pulse_new_match();
    n_checks++;
    if (lights !== 9'b000010000 || score_l !== 3'd0 || score_r !== 3'd0 || match_over !== 1'b0)
      $display("FAIL new_match got l=%b sl=%0d sr=%0d mo=%b exp l=000010000 0 0 0", lights, score_l, score_r, match_over);
    else n_pass++;
  endtask

  task automatic test_cpu_zero;
    cpu_en = 1'b1;
    difficulty = 10'd0;
    press_l = 1'b1;
    repeat (50) tick_once();
    n_checks++;
    if (lights !== 9'b000010000) $display("FAIL cpu_zero got=%b exp=%b", lights, 9'b000010000);
    else n_pass++;
    press_l = 1'b0;
    cpu_en = 1'b0;
  endtask

  task automatic test_cpu_max;
    cpu_en = 1'b1;
    difficulty = 10'd1023;
    do_reset();
    tick_once();
    n_checks++;
    if (lights !== 9'b000010000) $display("FAIL cpu_tick1 got=%b exp=%b", lights, 9'b000010000);
    else n_pass++;
    tick_once();
    n_checks++;
    if (lights !== 9'b000100000) $display("FAIL cpu_tick2 got=%b exp=%b", lights, 9'b000100000);
    else n_pass++;
    for (int t = 3; t <= 20; t++) begin
      tick_once();
      n_checks++;
      if (lights !== 9'b000100000) $display("FAIL cpu_tick%0d got=%b exp=%b", t, lights, 9'b000100000);
      else n_pass++;
    end
    cpu_en = 1'b0;
    difficulty = 10'd0;
  endtask

  task automatic test_reset_mid_hold;
    do_reset();
    repeat (4) press_r_once();
    press_r = 1'b1;
    tick_once();
    n_checks++;
    if (lights !== 9'd0 || rwin_r !== 1'b1) $display("FAIL pre_reset_hold got l=%b rw=%b exp l=0 rw=1", lights, rwin_r);
    else n_pass++;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (lights !== 9'b000010000 || score_r !== 3'd0 || rwin_r !== 1'b0 || match_over !== 1'b0)
      $display("FAIL async_reset got l=%b sr=%0d rw=%b mo=%b exp l=000010000 0 0 0", lights, score_r, rwin_r, match_over);
    else n_pass++;
    press_r = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_held_press();
    test_round_win();
    test_simultaneous();
    test_match();
    test_cpu_zero();
    test_cpu_max();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
